// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants for the unified I/D memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM states
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RD_WAIT = 1'b1;

    // Owner of the outstanding read
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int LAT_W    = 2;
    localparam int STARVE_W = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_prio.sv
`default_nettype none
// ============================================================================
// Module      : arb_prio
// Description : Data-priority pick between fetch and data ports with a
//               fetch starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic can_issue,
    output logic gnt_i,
    output logic gnt_d
);

    logic [STARVE_W-1:0] r_starve_q;
    logic [STARVE_W-1:0] w_starve_d;
    logic                w_i_wins;

    always_comb begin
        w_i_wins = i_req && (r_starve_q == STARVE_W'(STARVE_MAX));
        gnt_d    = can_issue && d_req && !w_i_wins;
        gnt_i    = can_issue && i_req && !gnt_d;

        // Count only cycles where fetch actually lost an issue slot to data
        w_starve_d = r_starve_q;
        if (!i_req || gnt_i) begin
            w_starve_d = '0;
        end else if (gnt_d && (r_starve_q != STARVE_W'(STARVE_MAX))) begin
            w_starve_d = r_starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_q <= '0;
        end else begin
            r_starve_q <= w_starve_d;
        end
    end

endmodule : arb_prio
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port memory arbiter sharing one unified memory between
//               the fetch and load/store ports, fixed read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    logic [0:0]       r_state_q, w_state_d;
    logic [LAT_W-1:0] r_cnt_q,   w_cnt_d;
    logic             r_owner_q, w_owner_d;

    logic w_resp;
    logic w_can_issue;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_rd_gnt;

    // Reset masks everything so all outputs read zero while it is held
    assign w_resp      = !reset && (r_state_q == RD_WAIT) && (r_cnt_q == '0);
    assign w_can_issue = !reset && ((r_state_q == IDLE) || w_resp);

    arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb_prio (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .d_req     (d_req),
        .can_issue (w_can_issue),
        .gnt_i     (w_gnt_i),
        .gnt_d     (w_gnt_d)
    );

    always_comb begin
        i_gnt    = w_gnt_i;
        d_gnt    = w_gnt_d;
        m_en     = w_gnt_i || w_gnt_d;
        m_we     = w_gnt_d && d_we;
        m_addr   = w_gnt_d ? d_addr : (w_gnt_i ? i_addr : '0);
        m_wdata  = (w_gnt_d && d_we) ? d_wdata : '0;

        i_rvalid = w_resp && (r_owner_q == OWN_I);
        d_rvalid = w_resp && (r_owner_q == OWN_D);
        i_rdata  = i_rvalid ? m_rdata : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;

        w_rd_gnt = w_gnt_i || (w_gnt_d && !d_we);

        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_owner_d = r_owner_q;
        if (w_rd_gnt) begin
            w_state_d = RD_WAIT;
            w_cnt_d   = LAT_W'(MEM_LAT - 1);
            w_owner_d = w_gnt_d ? OWN_D : OWN_I;
        end else if (w_resp) begin
            w_state_d = IDLE;
        end else if (r_state_q == RD_WAIT) begin
            w_cnt_d = r_cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_cnt_q   <= '0;
            r_owner_q <= OWN_I;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_owner_q <= w_owner_d;
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Randomized self-checking bench for mem_arbiter, two instances
//               (latency 1 / starve 4, latency 3 / starve 2).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int NI    = 2;
    localparam int LAT0  = 1;
    localparam int LAT1  = 3;
    localparam int SMAX0 = 4;
    localparam int SMAX1 = 2;
    localparam int NCYC  = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [NI];
    logic        i_req    [NI];
    logic [31:0] i_addr   [NI];
    logic        i_gnt    [NI];
    logic        i_rvalid [NI];
    logic [31:0] i_rdata  [NI];
    logic        d_req    [NI];
    logic        d_we     [NI];
    logic [31:0] d_addr   [NI];
    logic [31:0] d_wdata  [NI];
    logic        d_gnt    [NI];
    logic        d_rvalid [NI];
    logic [31:0] d_rdata  [NI];
    logic        m_en     [NI];
    logic        m_we     [NI];
    logic [31:0] m_addr   [NI];
    logic [31:0] m_wdata  [NI];
    logic [31:0] m_rdata  [NI];

    logic [31:0] rd_pipe  [NI][4];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_arbiter #(
            .MEM_LAT    ((g == 0) ? LAT0 : LAT1),
            .STARVE_MAX ((g == 0) ? SMAX0 : SMAX1)
        ) u_dut (
            .clk      (clk),
            .reset    (rst[g]),
            .i_req    (i_req[g]),
            .i_addr   (i_addr[g]),
            .i_gnt    (i_gnt[g]),
            .i_rvalid (i_rvalid[g]),
            .i_rdata  (i_rdata[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_gnt    (d_gnt[g]),
            .d_rvalid (d_rvalid[g]),
            .d_rdata  (d_rdata[g]),
            .m_en     (m_en[g]),
            .m_we     (m_we[g]),
            .m_addr   (m_addr[g]),
            .m_wdata  (m_wdata[g]),
            .m_rdata  (m_rdata[g])
        );
        assign m_rdata[g] = rd_pipe[g][((g == 0) ? LAT0 : LAT1) - 1];
    end

    function automatic logic [31:0] init_word(input int k, input int a);
        return 32'h1000_0000 * 32'(k + 1) + 32'(a) * 32'h0101_0103;
    endfunction

    // Backing memory: read data appears MEM_LAT cycles after a read strobe,
    // garbage on the bus otherwise.
    logic [31:0] bmem [NI][256];
    bit          mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int k = 0; k < NI; k++)
                for (int a = 0; a < 256; a++) bmem[k][a] = init_word(k, a);
            mem_loaded = 1'b1;
        end
        for (int k = 0; k < NI; k++) begin
            rd_pipe[k][0] <= (m_en[k] && !m_we[k]) ? bmem[k][m_addr[k][9:2]] : $urandom;
            for (int s = 1; s < 4; s++) rd_pipe[k][s] <= rd_pipe[k][s-1];
            if (m_en[k] && m_we[k]) bmem[k][m_addr[k][9:2]] = m_wdata[k];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [NI][256];
    bit          busy    [NI];
    int          due     [NI];
    bit          own_d   [NI];
    logic [31:0] rd_data [NI];
    int          starve  [NI];
    bit          exp_gi  [NI];
    bit          exp_gd  [NI];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input int k);
        int          lat, smax;
        bit          resp, can, gi, gd, rvi, rvd;
        logic [31:0] exp_addr;
        lat  = (k == 0) ? LAT0 : LAT1;
        smax = (k == 0) ? SMAX0 : SMAX1;
        if (rst[k]) begin
            check($sformatf("u%0d reset_outputs", k),
                  {i_gnt[k], i_rvalid[k], i_rdata[k], d_gnt[k], d_rvalid[k], d_rdata[k],
                   m_en[k], m_we[k], m_addr[k], m_wdata[k]}, '0);
            busy[k]   = 1'b0;
            starve[k] = 0;
            exp_gi[k] = 1'b0;
            exp_gd[k] = 1'b0;
            return;
        end
        resp = busy[k] && (due[k] == 0);
        can  = !busy[k] || resp;
        gd   = can && d_req[k] && !(i_req[k] && (starve[k] == smax));
        gi   = can && i_req[k] && !gd;
        rvi  = resp && !own_d[k];
        rvd  = resp && own_d[k];

        check($sformatf("u%0d grants", k), {i_gnt[k], d_gnt[k]}, {gi, gd});
        check($sformatf("u%0d strobe", k), {m_en[k], m_we[k]}, {gi || gd, gd && d_we[k]});
        if (gi || gd) begin
            exp_addr = gd ? d_addr[k] : i_addr[k];
            check($sformatf("u%0d m_addr", k), m_addr[k], exp_addr);
        end
        if (gd && d_we[k])
            check($sformatf("u%0d m_wdata", k), m_wdata[k], d_wdata[k]);
        check($sformatf("u%0d i_resp", k), {i_rvalid[k], i_rdata[k]},
              {rvi, rvi ? rd_data[k] : 32'd0});
        check($sformatf("u%0d d_resp", k), {d_rvalid[k], d_rdata[k]},
              {rvd, rvd ? rd_data[k] : 32'd0});

        if (!i_req[k] || gi) starve[k] = 0;
        else if (gd && starve[k] < smax) starve[k]++;

        if (gd && d_we[k]) ref_mem[k][d_addr[k][9:2]] = d_wdata[k];
        if (resp) busy[k] = 1'b0;
        else if (busy[k]) due[k]--;
        if (gi || (gd && !d_we[k])) begin
            busy[k]    = 1'b1;
            due[k]     = lat - 1;
            own_d[k]   = gd;
            rd_data[k] = ref_mem[k][gd ? d_addr[k][9:2] : i_addr[k][9:2]];
        end
        exp_gi[k] = gi;
        exp_gd[k] = gd;
    endtask

    // Requests are held until granted, then a new one is drawn
    task automatic drive(input int k, input int pi, input int pd, input bit allow_rst);
        rst[k] = allow_rst && busy[k] && ($urandom_range(0, 15) == 0);
        if (!i_req[k] || exp_gi[k]) begin
            i_req[k]  = ($urandom_range(0, 99) < pi);
            i_addr[k] = 32'($urandom_range(0, 31)) << 2;
        end
        if (!d_req[k] || exp_gd[k]) begin
            d_req[k]   = ($urandom_range(0, 99) < pd);
            d_we[k]    = $urandom_range(0, 1) == 1;
            d_addr[k]  = 32'($urandom_range(0, 31)) << 2;
            d_wdata[k] = $urandom;
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k]     = 1'b1;
            i_req[k]   = 1'b0;
            i_addr[k]  = '0;
            d_req[k]   = 1'b0;
            d_we[k]    = 1'b0;
            d_addr[k]  = '0;
            d_wdata[k] = '0;
            busy[k]    = 1'b0;
            due[k]     = 0;
            own_d[k]   = 1'b0;
            rd_data[k] = '0;
            starve[k]  = 0;
            exp_gi[k]  = 1'b0;
            exp_gd[k]  = 1'b0;
            for (int a = 0; a < 256; a++) ref_mem[k][a] = init_word(k, a);
        end

        repeat (3) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < NI; k++) model_step(k);
        end

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (c < 30)       drive(k, 100, 0, 1'b0);
                else if (c < 100) drive(k, 100, 100, 1'b0);
                else              drive(k, 60, 55, 1'b1);
            end
            #1;
            for (int k = 0; k < NI; k++) model_step(k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one unified instruction/data memory between the pipeline's fetch port and its data (load/store) port. It sits between `riscvpipeline` and a single backing memory, and replaces the separate `imem`/`dmem` pair in the top level. Each port raises a request and holds it; the arbiter grants one access per cycle, gives the data port priority with a starvation guard for fetch, and returns read data after a fixed memory latency. Stall signals derive directly from request-without-grant.

## Interface
- `MEM_LAT`, default 1: backing-memory read latency in cycles; legal range 1..4.
- `STARVE_MAX`, default 4: number of consecutive denied fetch cycles after which fetch wins the next contended cycle; legal range 1..15.
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `reset`  in  1  — synchronous, active-high.
- `i_req`  in  1  — fetch request; held until `i_gnt`.
- `i_addr`  in  32  — fetch byte address; must stay stable while `i_req` is high and `i_gnt` is low.
- `i_gnt`  out  1  — fetch request accepted this cycle.
- `i_rvalid`  out  1  — one-cycle pulse; `i_rdata` is valid.
- `i_rdata`  out  32  — instruction word.
- `d_req`  in  1  — data request; held until `d_gnt`.
- `d_we`  in  1  — 1 = store, 0 = load.
- `d_addr`  in  32  — data byte address; must stay stable while pending.
- `d_wdata`  in  32  — store data; must stay stable while pending.
- `d_gnt`  out  1  — data request accepted; for a store, this is also completion.
- `d_rvalid`  out  1  — one-cycle pulse; `d_rdata` is valid.
- `d_rdata`  out  32  — load data.
- `m_en`  out  1  — memory access strobe.
- `m_we`  out  1  — memory write enable.
- `m_addr`  out  32  — memory address, passed through unmodified from the granted port.
- `m_wdata`  out  32  — memory write data.
- `m_rdata`  in  32  — memory read data, valid exactly `MEM_LAT` cycles after a read strobe.

## Operation
- **States**
  - `IDLE`: no read outstanding.
  - `RD_WAIT`: one read outstanding; a latency counter runs and the owner (I or D) is recorded.
- **Issue condition.** A grant may issue in a cycle when the state is `IDLE`, or in the final `RD_WAIT` cycle (the cycle in which the response returns).
- **Arbitration**
  - Only one request present: that port is granted.
  - Both present: D is granted unless `starve_cnt == STARVE_MAX`, in which case I is granted.
- **Starvation counter (`starve_cnt`)**
  - Increments when `i_req` is high, the issue condition is met, and D is granted.
  - Clears on any I grant, or in any cycle with `i_req` low.
  - Saturates at `STARVE_MAX`.
- **Memory drive on grant.** The grant drives `m_en`=1, `m_addr`, `m_we`, and `m_wdata` combinationally in the same cycle.
- **Store grant.** The write commits at the end of the cycle. No response follows, and the state is unchanged.
- **Read grant.**
  - The state moves to `RD_WAIT` with counter = `MEM_LAT`-1 and the owner recorded.
  - When the counter reaches 0 (in `RD_WAIT`), `m_rdata` is forwarded combinationally to the owner's `rdata` and `rvalid` pulses for one cycle.
  - In that same cycle the state goes to `IDLE`, or re-enters `RD_WAIT` if a new read is granted.
- **Idle outputs.** When no port is granted, `m_en`=0 and `m_we`=0. `i_rdata`/`d_rdata` are 0 when their `rvalid` is low.
- **Pipeline stalls.** The pipeline derives its stalls as `StallF = i_req & ~i_gnt` and `StallM = d_req & ~d_gnt`.

## Timing
- **Reset values.** All outputs are 0, the state is `IDLE`, and `starve_cnt` is 0.
- **Reset during `RD_WAIT`.** The pending read is dropped and no `rvalid` is ever produced for it.
- **Read latency.** Grant in cycle t produces `rvalid` in cycle t+`MEM_LAT`.
- **Read throughput.**
  - `MEM_LAT`=1: back-to-back reads, one per cycle.
  - `MEM_LAT`=N: one read per N cycles.
- **Writes during an outstanding read.** A store is blocked until the response cycle. It is never issued concurrently with an outstanding read.
- **Response cycle.** The response for one port and a grant to the other port may occur in the same cycle.
- **Request held through grant.** A request still high in the cycle after its grant is treated as a new request.

## Structure
- **Package `mem_arb_pkg`:**
  - state enum (`IDLE`, `RD_WAIT`)
  - owner encoding (`OWN_I`, `OWN_D`)
  - `LAT_W` = 2, the width of the latency counter
- **Sub-module `arb_prio`:**
  - combinational D/I pick
  - `starve_cnt` register
  - ports: `clk`, `reset`, `i_req`, `d_req`, `can_issue`, `gnt_i`, `gnt_d`
- **Top FSM:** the latency counter and response routing stay in the `mem_arbiter` top level.

## Test plan
- **Fetch only, `MEM_LAT`=1.** Fetch-only reads at 0x00, 0x04, 0x08 → `i_gnt` every cycle; `i_rvalid` one cycle later with the stored words.
- **Store then fetch.** `d_req` store (0x64, 25) concurrent with `i_req` → `d_gnt` first with `m_we`=1, `m_addr`=0x64; `i_gnt` on the next cycle. A later load of 0x64 returns 25.
- **Starvation guard.** `d_req` and `i_req` both held continuously, `STARVE_MAX`=4 → D is granted 4 times, then I once, repeating.
- **Latency 3.** `MEM_LAT`=3 load at t → `d_rvalid` at t+3. A fetch is granted at t+3, and is not granted at t+1 or t+2.
- **Reset mid-read.** Reset asserted during `RD_WAIT` → no `rvalid` appears, all outputs are 0 the next cycle, and a fresh read then behaves normally.
